data_mem_access: RTL and testbench



---
 rtl/data_mem_access.sv | 174 +++++++++++++++++
 tb/tb_data_mem_access.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// data_mem_access: MEM-stage load/store responder for the RV32IM pipeline.
// Converts byte/half/word accesses into word-aligned memory requests with
// byte enables, runs the request/acknowledge handshake with data memory,
// stalls the pipeline through BUSYWAIT, and returns extended load data.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses pulse MISALIGNED and are not issued
//   undefined - MISALIGNED tied 0; misaligned H/W forced to natural boundary
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   MEM_READ_EN/WRITE_EN, FUNC3, ADDRESS, WRITE_DATA  pipeline request
//   READ_DATA, BUSYWAIT, MISALIGNED                   pipeline response
//   DMEM_READ/WRITE, DMEM_ADDR, DMEM_BYTE_EN, DMEM_WDATA  memory request
//   DMEM_RDATA, DMEM_ACK                              memory response
module data_mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ_EN,
    input  logic              MEM_WRITE_EN,
    input  logic [2:0]        FUNC3,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic [31:0]       READ_DATA,
    output logic              BUSYWAIT,
    output logic              MISALIGNED,
    output logic              DMEM_READ,
    output logic              DMEM_WRITE,
    output logic [ADDR_W-1:0] DMEM_ADDR,
    output logic [3:0]        DMEM_BYTE_EN,
    output logic [31:0]       DMEM_WDATA,
    input  logic [31:0]       DMEM_RDATA,
    input  logic              DMEM_ACK
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        req;
    logic        is_b, is_h, is_w;
    logic        access_ok;
    logic [1:0]  off_eff;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign req  = MEM_READ_EN | MEM_WRITE_EN;
    assign is_b = (FUNC3 == 3'b000) || (FUNC3 == 3'b100);
    assign is_h = (FUNC3 == 3'b001) || (FUNC3 == 3'b101);
    assign is_w = !(is_b || is_h);  // unlisted codes behave as word

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    assign mis        = (is_h && ADDRESS[0]) || (is_w && (ADDRESS[1:0] != 2'b00));
    assign access_ok  = req && !mis;
    assign off_eff    = ADDRESS[1:0];
    assign MISALIGNED = !RESET && (state_q == IDLE) && req && mis;
`else
    assign access_ok  = req;
    // Misaligned halves/words snap down to their natural boundary.
    assign off_eff    = is_w ? 2'b00 : (is_h ? {ADDRESS[1], 1'b0} : ADDRESS[1:0]);
    assign MISALIGNED = 1'b0;
`endif

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WRITE_DATA;
        if (is_b) begin
            be_new    = 4'b0001 << off_eff;
            wdata_new = {4{WRITE_DATA[7:0]}};
        end else if (is_h) begin
            be_new    = 4'b0011 << off_eff;
            wdata_new = {2{WRITE_DATA[15:0]}};
        end
    end

    // Selected lane moved down to bit 0 before extension.
    assign lane = DMEM_RDATA >> {off_q, 3'b000};

    always_comb begin
        case (func3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (access_ok) begin
                    state_d = ACCESS;
                    // A simultaneous read and write is a store.
                    rd_d    = MEM_READ_EN && !MEM_WRITE_EN;
                    wr_d    = MEM_WRITE_EN;
                    addr_d  = {ADDRESS[ADDR_W-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    func3_d = FUNC3;
                    off_d   = off_eff;
                end
            end
            ACCESS: begin
                if (DMEM_ACK) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        rdata_d = load_ext;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall is gated by RESET so it drops without waiting for a clock edge.
    assign BUSYWAIT     = !RESET && (((state_q == IDLE) && access_ok) || (state_q == ACCESS));
    assign READ_DATA    = rdata_q;
    assign DMEM_READ    = rd_q;
    assign DMEM_WRITE   = wr_q;
    assign DMEM_ADDR    = addr_q;
    assign DMEM_BYTE_EN = be_q;
    assign DMEM_WDATA   = wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// tb_data_mem_access: directed self-checking bench for data_mem_access.
// Each test task drives one scenario and checks its own results inline.
module tb_data_mem_access;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ_EN, MEM_WRITE_EN;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS, WRITE_DATA, READ_DATA;
    logic        BUSYWAIT, MISALIGNED, DMEM_READ, DMEM_WRITE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic        DMEM_ACK;

    int tests = 0;
    int fails = 0;

    // Observations recorded by run_access.
    int          busy_cnt;
    logic        saw_rd, saw_wr, done_busy, done_req;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    always #5 CLK = ~CLK;

    data_mem_access #(.ADDR_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN),
        .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
        .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_BYTE_EN(DMEM_BYTE_EN), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK)
    );

    // Stimulus only: issues one access, ACKs in cycle t+ack_dly, records outputs.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_dly);
        @(posedge CLK); #1;
        MEM_READ_EN = rd; MEM_WRITE_EN = wr; FUNC3 = f3; ADDRESS = addr;
        WRITE_DATA = wd; DMEM_RDATA = rdat; DMEM_ACK = 1'b0;
        busy_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        @(negedge CLK);
        if (BUSYWAIT) busy_cnt++;
        if (DMEM_READ) saw_rd = 1'b1;
        if (DMEM_WRITE) saw_wr = 1'b1;
        for (int c = 1; c <= ack_dly; c++) begin
            @(posedge CLK); #1;
            if (c == ack_dly) DMEM_ACK = 1'b1;
            @(negedge CLK);
            if (BUSYWAIT) busy_cnt++;
            if (DMEM_READ) saw_rd = 1'b1;
            if (DMEM_WRITE) saw_wr = 1'b1;
            if (c == 1) begin
                obs_addr = DMEM_ADDR; obs_be = DMEM_BYTE_EN; obs_wdata = DMEM_WDATA;
            end
        end
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0; MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0;
        @(negedge CLK);
        done_busy = BUSYWAIT;
        done_req  = DMEM_READ | DMEM_WRITE;
        if (BUSYWAIT) busy_cnt++;
        @(posedge CLK); #1;
        @(negedge CLK);
        if (BUSYWAIT) busy_cnt++;
    endtask

    task automatic test_reset;
        RESET = 1'b1; MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0; FUNC3 = 3'b000;
        ADDRESS = '0; WRITE_DATA = '0; DMEM_RDATA = '0; DMEM_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        tests++;
        if ({READ_DATA, BUSYWAIT, MISALIGNED, DMEM_READ, DMEM_WRITE, DMEM_ADDR,
             DMEM_BYTE_EN, DMEM_WDATA} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rd=%h busy=%b dr=%b dw=%b addr=%h be=%b wd=%h, required all zero",
                     READ_DATA, BUSYWAIT, DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_BYTE_EN, DMEM_WDATA);
        end
    endtask

    task automatic test_lb_sign;
        run_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 2);
        tests++;
        if (obs_addr !== 32'h1000) begin fails++; $display("FAIL lb_addr: got %h required %h", obs_addr, 32'h1000); end
        tests++;
        if (obs_be !== 4'b1000) begin fails++; $display("FAIL lb_be: got %b required 1000", obs_be); end
        tests++;
        if (READ_DATA !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data: got %h required ffffff80", READ_DATA); end
        tests++;
        if (busy_cnt !== 3) begin fails++; $display("FAIL lb_busy_cycles: got %0d required 3", busy_cnt); end
        tests++;
        if (!saw_rd || saw_wr || done_busy || done_req) begin
            fails++;
            $display("FAIL lb_handshake: got rd=%b wr=%b done_busy=%b done_req=%b required 1 0 0 0",
                     saw_rd, saw_wr, done_busy, done_req);
        end
    endtask

    task automatic test_lhu_zero;
        run_access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h92345678, 1);
        tests++;
        if (obs_be !== 4'b1100) begin fails++; $display("FAIL lhu_be: got %b required 1100", obs_be); end
        tests++;
        if (READ_DATA !== 32'h00009234) begin fails++; $display("FAIL lhu_data: got %h required 00009234", READ_DATA); end
        run_access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'h92345678, 3);
        tests++;
        if (READ_DATA !== 32'hFFFF9234) begin fails++; $display("FAIL lh_data: got %h required ffff9234", READ_DATA); end
        tests++;
        if (busy_cnt !== 4) begin fails++; $display("FAIL lh_busy_cycles: got %0d required 4", busy_cnt); end
        run_access(1'b1, 1'b0, 3'b100, 32'h0001, 32'h0, 32'h1234F600, 1);
        tests++;
        if (READ_DATA !== 32'h000000F6) begin fails++; $display("FAIL lbu_data: got %h required 000000f6", READ_DATA); end
        run_access(1'b1, 1'b0, 3'b010, 32'h0040, 32'h0, 32'hCAFEF00D, 1);
        tests++;
        if (READ_DATA !== 32'hCAFEF00D || obs_be !== 4'b1111) begin
            fails++; $display("FAIL lw_data: got %h be=%b required cafef00d be=1111", READ_DATA, obs_be);
        end
    endtask

    task automatic test_sh_store;
        run_access(1'b0, 1'b1, 3'b001, 32'h0006, 32'hDEADBEEF, 32'h11111111, 2);
        tests++;
        if (!saw_wr || saw_rd) begin fails++; $display("FAIL sh_req: got wr=%b rd=%b required 1 0", saw_wr, saw_rd); end
        tests++;
        if (obs_addr !== 32'h0004 || obs_be !== 4'b1100) begin
            fails++; $display("FAIL sh_addr_be: got %h %b required 00000004 1100", obs_addr, obs_be);
        end
        tests++;
        if (obs_wdata !== 32'hBEEFBEEF) begin fails++; $display("FAIL sh_wdata: got %h required beefbeef", obs_wdata); end
        tests++;
        if (READ_DATA !== 32'hCAFEF00D) begin fails++; $display("FAIL sh_rdata_hold: got %h required cafef00d", READ_DATA); end
    endtask

    task automatic test_rw_together;
        run_access(1'b1, 1'b1, 3'b000, 32'h0011, 32'h123456A5, 32'h0, 1);
        tests++;
        if (saw_rd || !saw_wr) begin fails++; $display("FAIL rw_store: got rd=%b wr=%b required 0 1", saw_rd, saw_wr); end
        tests++;
        if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL rw_be_wdata: got %b %h required 0010 a5a5a5a5", obs_be, obs_wdata);
        end
        tests++;
        if (READ_DATA !== 32'hCAFEF00D) begin fails++; $display("FAIL rw_rdata_hold: got %h required cafef00d", READ_DATA); end
    endtask

    task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge CLK); #1;
        MEM_READ_EN = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0002; DMEM_RDATA = 32'h55555555;
        @(negedge CLK);
        tests++;
        if (MISALIGNED !== 1'b1 || BUSYWAIT !== 1'b0) begin
            fails++; $display("FAIL trap_pulse: got mis=%b busy=%b required 1 0", MISALIGNED, BUSYWAIT);
        end
        @(posedge CLK); #1 MEM_READ_EN = 1'b0;
        @(negedge CLK);
        tests++;
        if (MISALIGNED !== 1'b0 || DMEM_READ !== 1'b0 || READ_DATA !== 32'hCAFEF00D) begin
            fails++; $display("FAIL trap_after: got mis=%b dr=%b rd=%h required 0 0 cafef00d",
                              MISALIGNED, DMEM_READ, READ_DATA);
        end
`else
        run_access(1'b1, 1'b0, 3'b010, 32'h0002, 32'h0, 32'h89ABCDEF, 1);
        tests++;
        if (obs_addr !== 32'h0000 || obs_be !== 4'b1111) begin
            fails++; $display("FAIL mis_lw_force: got %h %b required 00000000 1111", obs_addr, obs_be);
        end
        tests++;
        if (READ_DATA !== 32'h89ABCDEF || MISALIGNED !== 1'b0) begin
            fails++; $display("FAIL mis_lw_data: got %h mis=%b required 89abcdef 0", READ_DATA, MISALIGNED);
        end
`endif
    endtask

    task automatic test_stray_ack;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0BADF00D;
        @(negedge CLK);
        @(posedge CLK); #1 DMEM_ACK = 1'b0;
        @(negedge CLK);
        tests++;
        if (BUSYWAIT || DMEM_READ || DMEM_WRITE || READ_DATA !== 32'h89ABCDEF && READ_DATA !== 32'hCAFEF00D) begin
            fails++; $display("FAIL stray_ack: got busy=%b dr=%b dw=%b rd=%h required idle and unchanged",
                              BUSYWAIT, DMEM_READ, DMEM_WRITE, READ_DATA);
        end
    endtask

    task automatic test_reset_mid_access;
        @(posedge CLK); #1;
        MEM_READ_EN = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0100; DMEM_ACK = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        tests++;
        if (DMEM_READ !== 1'b1) begin fails++; $display("FAIL rst_pre: got dr=%b required 1", DMEM_READ); end
        #1 RESET = 1'b1;
        #1;
        tests++;
        if (DMEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
            fails++; $display("FAIL rst_async: got dr=%b busy=%b required 0 0", DMEM_READ, BUSYWAIT);
        end
        MEM_READ_EN = 1'b0;
        @(posedge CLK); #1 RESET = 1'b0;
        run_access(1'b0, 1'b1, 3'b010, 32'h0200, 32'h13579BDF, 32'h0, 2);
        tests++;
        if (!saw_wr || obs_addr !== 32'h0200 || obs_wdata !== 32'h13579BDF || busy_cnt !== 3) begin
            fails++; $display("FAIL rst_sw_after: got wr=%b addr=%h wd=%h busy=%0d required 1 00000200 13579bdf 3",
                              saw_wr, obs_addr, obs_wdata, busy_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_lb_sign;
        test_lhu_zero;
        test_sh_store;
        test_rw_together;
        test_misaligned;
        test_stray_ack;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
